// File: rtl/dmem_byte_seq_ctrl_if.sv
// Bus between the MEM stage plus byte-wide data memory (master side)
// and the word-to-byte sequencing controller (slave side).
interface dmem_byte_seq_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (
        output rd_req, wr_req, addr, wdata, mem_rdata,
        input  rdata, ready, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  rd_req, wr_req, addr, wdata, mem_rdata,
        output rdata, ready, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/dmem_byte_seq_ctrl.sv
// Splits one 32-bit word access into four big-endian byte beats on a
// byte-wide memory port, holding ready low until the word is complete.
module dmem_byte_seq_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BEAT_WAIT = 0
) (
    input logic                 clk,
    input logic                 rst,
    dmem_byte_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [2:0] WAIT_MAX = 3'(BEAT_WAIT);

    state_t            state;
    state_t            state_next;
    logic [1:0]        beat;
    logic [2:0]        wait_cnt;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata_lat;
    logic              op_wr;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_next;
    logic [DATA_W-1:0] rdata_q;
    logic              beat_done;
    logic [7:0]        wbyte;
    logic              ready_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [7:0]        mem_wdata_c;
    logic              mem_we_c;
    logic              mem_re_c;

    // Beat 0 carries the most significant byte (big-endian).
    always_comb begin
        wbyte = 8'h00;
        case (beat)
            2'd0: wbyte = wdata_lat[31:24];
            2'd1: wbyte = wdata_lat[23:16];
            2'd2: wbyte = wdata_lat[15:8];
            default: wbyte = wdata_lat[7:0];
        endcase
    end

    always_comb begin
        state_next  = state;
        ready_c     = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = 8'h00;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        shadow_next = shadow;
        beat_done   = (wait_cnt == WAIT_MAX);
        case (state)
            IDLE: begin
                ready_c = ~(bus.rd_req | bus.wr_req);
                if (bus.rd_req | bus.wr_req) state_next = XFER;
            end
            XFER: begin
                mem_addr_c = base + ADDR_W'(beat);
                if (op_wr) begin
                    mem_wdata_c = wbyte;
                    // Strobe only on the last wait cycle: one write per byte.
                    mem_we_c    = beat_done;
                end else begin
                    mem_re_c = 1'b1;
                    if (beat_done) begin
                        case (beat)
                            2'd0: shadow_next[31:24] = bus.mem_rdata;
                            2'd1: shadow_next[23:16] = bus.mem_rdata;
                            2'd2: shadow_next[15:8]  = bus.mem_rdata;
                            default: shadow_next[7:0] = bus.mem_rdata;
                        endcase
                    end
                end
                if (beat_done && beat == 2'd3) state_next = DONE;
            end
            DONE: begin
                ready_c    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            wait_cnt  <= 3'd0;
            base      <= '0;
            wdata_lat <= '0;
            op_wr     <= 1'b0;
            shadow    <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.rd_req | bus.wr_req) begin
                        // Low address bits are ignored so beats never leave the word.
                        base      <= bus.addr & ~ADDR_W'(3);
                        wdata_lat <= bus.wdata;
                        op_wr     <= bus.wr_req;
                        beat      <= 2'd0;
                        wait_cnt  <= 3'd0;
                    end
                end
                XFER: begin
                    shadow <= shadow_next;
                    if (beat_done) begin
                        wait_cnt <= 3'd0;
                        beat     <= beat + 2'd1;
                        if (beat == 2'd3 && !op_wr) rdata_q <= shadow_next;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = ready_c;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_re    = mem_re_c;
endmodule

// File: tb/tb_dmem_byte_seq_ctrl.sv
// Directed bench for dmem_byte_seq_ctrl: a zero-wait instance for the main
// sequence and a BEAT_WAIT=2 instance for wait-state timing.
module tb_dmem_byte_seq_ctrl;
    logic clk;
    logic rst;
    logic mem_init;

    int n_cmp;
    int n_fail;

    logic [7:0]  mem0 [256];
    logic [7:0]  mem2 [256];
    logic [7:0]  exp_mem [256];
    logic [31:0] model_rdata;
    logic [31:0] exp_rd [$];
    logic [39:0] exp_wr [$];

    dmem_byte_seq_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    dmem_byte_seq_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    dmem_byte_seq_ctrl #(.ADDR_W(32), .DATA_W(32), .BEAT_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    dmem_byte_seq_ctrl #(.ADDR_W(32), .DATA_W(32), .BEAT_WAIT(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus0.mem_rdata = mem0[bus0.mem_addr[7:0]];
    assign bus2.mem_rdata = mem2[bus2.mem_addr[7:0]];

    // Memory models; bus2 memory holds A1 B2 C3 D4 at 0x20.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 8'hEE;
                mem2[i] <= 8'(i) ^ 8'h5A;
            end
            mem2[8'h20] <= 8'hA1;
            mem2[8'h21] <= 8'hB2;
            mem2[8'h22] <= 8'hC3;
            mem2[8'h23] <= 8'hD4;
        end else if (bus0.mem_we === 1'b1) begin
            mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Every byte strobe must match the next expected write in order.
    always @(negedge clk) begin
        if (!rst && bus0.mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                assert (exp_wr.size() != 0) else begin
                    n_fail++;
                    $error("[TB] FAIL wr_unexpected: observed write 0x%08h=0x%02h expected none",
                           bus0.mem_addr, bus0.mem_wdata);
                end
            end else begin
                logic [39:0] e;
                e = exp_wr.pop_front();
                check_output("wr_addr", bus0.mem_addr, e[39:8]);
                check_output("wr_data", {24'h0, bus0.mem_wdata}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] base;
        logic [7:0]  b;
        bus0.rd_req = rd;
        bus0.wr_req = wr;
        bus0.addr   = a;
        bus0.wdata  = wd;
        base = {a[31:2], 2'b00};
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                b = wd[8*(3-i) +: 8];
                exp_wr.push_back({base + 32'(i), b});
                exp_mem[base[7:0] + 8'(i)] = b;
            end
        end else if (rd) begin
            model_rdata = {exp_mem[base[7:0]], exp_mem[base[7:0] + 8'd1],
                           exp_mem[base[7:0] + 8'd2], exp_mem[base[7:0] + 8'd3]};
        end
        exp_rd.push_back(model_rdata);
    endtask

    // Counts ready-low cycles up to the DONE cycle, scrambling addr/wdata mid-access.
    task automatic wait_done(input int exp_low, input string tag);
        int low;
        bit seen;
        logic [31:0] e;
        low  = 0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus0.ready === 1'b1) begin
                seen = 1;
                break;
            end
            low++;
            if (low == 2) begin
                bus0.addr  = $urandom;
                bus0.wdata = $urandom;
            end
        end
        check_output({tag, "_low_cycles"}, low, exp_low);
        e = exp_rd.pop_front();
        if (seen) check_output({tag, "_rdata"}, bus0.rdata, e);
        check_output({tag, "_wr_drained"}, exp_wr.size(), 0);
    endtask

    task automatic release_req();
        @(posedge clk);
        #1;
        bus0.rd_req = 1'b0;
        bus0.wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int low;
        n_cmp = 0;
        n_fail = 0;
        model_rdata = 32'h0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'hEE;
        rst = 1'b1;
        mem_init = 1'b1;
        bus0.rd_req = 1'b0; bus0.wr_req = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        bus2.rd_req = 1'b0; bus2.wr_req = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;

        @(negedge clk);
        check_output("rst_ready", bus0.ready, 1);
        check_output("rst_rdata", bus0.rdata, 0);
        check_output("rst_mem_we", bus0.mem_we, 0);
        check_output("rst_mem_re", bus0.mem_re, 0);
        check_output("rst_mem_addr", bus0.mem_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write to 0x10 aborted by reset after beat 1 completes.
        bus0.wr_req = 1'b1;
        bus0.addr   = 32'h10;
        bus0.wdata  = 32'h55667788;
        exp_wr.push_back({32'h10, 8'h55});
        exp_wr.push_back({32'h11, 8'h66});
        exp_mem[8'h10] = 8'h55;
        exp_mem[8'h11] = 8'h66;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus0.wr_req = 1'b0;
        @(negedge clk);
        check_output("abort_ready", bus0.ready, 1);
        check_output("abort_mem_we", bus0.mem_we, 0);
        check_output("abort_mem_addr", bus0.mem_addr, 0);
        check_output("abort_mem_wdata", {24'h0, bus0.mem_wdata}, 0);
        check_output("abort_rdata", bus0.rdata, 0);
        check_output("abort_wr_drained", exp_wr.size(), 0);
        check_output("abort_byte10", {24'h0, mem0[8'h10]}, {24'h0, exp_mem[8'h10]});
        check_output("abort_byte11", {24'h0, mem0[8'h11]}, {24'h0, exp_mem[8'h11]});
        check_output("abort_byte12", {24'h0, mem0[8'h12]}, {24'h0, exp_mem[8'h12]});
        check_output("abort_byte13", {24'h0, mem0[8'h13]}, {24'h0, exp_mem[8'h13]});
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        apply_stimulus(1'b0, 1'b1, 32'h20, 32'hA1B2C3D4);
        wait_done(5, "wr20");
        release_req();

        apply_stimulus(1'b1, 1'b0, 32'h22, 32'h0);
        wait_done(5, "rd22");
        release_req();
        @(negedge clk);
        check_output("rd22_held", bus0.rdata, 32'hA1B2C3D4);
        @(posedge clk);
        #1;

        apply_stimulus(1'b0, 1'b1, 32'h24, 32'hDEADBEEF);
        wait_done(5, "wr24");
        release_req();

        // Request held across DONE with a new address starts the next access at once.
        apply_stimulus(1'b0, 1'b1, 32'h28, 32'h0BADF00D);
        wait_done(5, "b2b_first");
        apply_stimulus(1'b0, 1'b1, 32'h30, 32'hCAFE1234);
        wait_done(5, "b2b_second");
        release_req();

        apply_stimulus(1'b1, 1'b0, 32'h30, 32'h0);
        wait_done(5, "rd30");
        release_req();

        apply_stimulus(1'b1, 1'b1, 32'h40, 32'h11223344);
        wait_done(5, "illegal");
        release_req();

        apply_stimulus(1'b1, 1'b0, 32'h41, 32'h0);
        wait_done(5, "rd40");
        release_req();

        apply_stimulus(1'b1, 1'b0, 32'h24, 32'h0);
        wait_done(5, "rd24");
        release_req();

        // Wait-state instance: each byte address held for three cycles.
        bus2.rd_req = 1'b1;
        bus2.addr   = 32'h20;
        low = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus2.ready === 1'b1) break;
            if (low >= 1) begin
                check_output("w2_mem_addr", bus2.mem_addr, 32'h20 + 32'((low - 1) / 3));
                check_output("w2_mem_re", bus2.mem_re, 1);
            end
            low++;
        end
        check_output("w2_low_cycles", low, 13);
        check_output("w2_rdata", bus2.rdata, 32'hA1B2C3D4);
        @(posedge clk);
        #1 bus2.rd_req = 1'b0;
        @(negedge clk);
        check_output("w2_idle_ready", bus2.ready, 1);
        check_output("w2_rdata_held", bus2.rdata, 32'hA1B2C3D4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
